stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-cycle initiator that drives the memory stage's stack port for CALL, RET, interrupt entry (INT) and RTI. It latches the PC and flags at start, then issues one push or pop per accepted memory cycle. The memory stage uses address select 00 (SP-relative) for all of these. For pops, it assembles the returned 16-bit words into a 32-bit PC and 3-bit flags and presents them with one-cycle load strobes. It also holds the pipeline stall asserted while a sequence is in flight.

## Interface
Parameters
- DATA_W, 16, memory word width
- PC_W, 32, program counter width (two words)
- FLAG_W, 3, flag bits stored in the low bits of a word

Ports
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- start_call  in  1  begin CALL sequence (push PC)
- start_ret  in  1  begin RET sequence (pop PC)
- start_int  in  1  begin interrupt entry (push flags, then push PC)
- start_rti  in  1  begin RTI sequence (pop PC, then pop flags)
- pc_in  in  32  PC to save, latched at start
- flags_in  in  3  flags to save, latched at start
- mem_ready  in  1  memory accepts the current request this cycle
- mem_rdata  in  16  pop data, valid the cycle after an accepted pop
- memory_push  out  1  push request (SP decrement then write)
- memory_pop  out  1  pop request (SP increment then read)
- memory_write  out  1  asserted with every push
- memory_read  out  1  asserted with every pop
- memory_address_select  out  2  constant 2'b00 (SP)
- memory_write_src_select  out  2  00 flags, 01 PC[31:16], 10 PC[15:0]
- stall  out  1  freeze upstream pipeline
- busy  out  1  state ≠ IDLE
- pc_out  out  32  restored PC
- pc_load  out  1  one-cycle strobe, pc_out valid
- flags_out  out  3  restored flags
- flags_load  out  1  one-cycle strobe, flags_out valid

## Operation
- Reset (reset=0 at an edge):
  - state ← IDLE.
  - All request outputs, strobes, busy, pc_out, flags_out and the internal latches ← 0.
  - Reset aborts any in-flight sequence immediately; no partial strobe is issued.
- Start arbitration in IDLE: INT > RTI > CALL > RET. The losing starts are dropped; the requester must reassert them.
- Starts are ignored while busy.
- On an accepted start, pc_in and flags_in are latched. Later changes to these inputs have no effect.
- States: IDLE, PUSH_FL, PUSH_HI, PUSH_LO, POP_LO, CAP_LO, POP_HI, CAP_HI, POP_FL, CAP_FL, DONE.
- Sequences:
  - CALL: PUSH_HI → PUSH_LO → DONE
  - INT: PUSH_FL → PUSH_HI → PUSH_LO → DONE
  - RET: POP_LO → CAP_LO → POP_HI → CAP_HI → DONE
  - RTI: POP_LO → CAP_LO → POP_HI → CAP_HI → POP_FL → CAP_FL → DONE
- PUSH_x states:
  - Outputs: memory_push=1, memory_write=1, src select per word (FL 00, HI 01, LO 10).
  - Advance only on a cycle with mem_ready=1; otherwise hold all outputs stable.
- POP_x states:
  - Outputs: memory_pop=1, memory_read=1.
  - Advance on mem_ready=1.
- CAP_x states (one cycle each, no request asserted):
  - CAP_LO: pc_out[15:0] ← mem_rdata.
  - CAP_HI: pc_out[31:16] ← mem_rdata.
  - CAP_FL: flags_out ← mem_rdata[2:0].
  - mem_rdata upper bits are ignored for flags.
- At most one of memory_push / memory_pop is high in any cycle. Never both.
- DONE (one cycle):
  - pc_load=1 for RET/RTI.
  - flags_load=1 for RTI only.
  - Then → IDLE.
  - CALL and INT assert no load strobes.

## Timing
- Requests and strobes are Moore outputs, registered from state.
- stall = busy OR any start input high. The start cycle stalls combinationally.
- stall is low again the cycle after DONE.
- Latency from start edge to DONE, with mem_ready held high:
  - CALL: 3 cycles
  - INT: 4 cycles
  - RET: 5 cycles
  - RTI: 7 cycles
- Each low cycle of mem_ready in a request state adds exactly one cycle.
- Pop data is sampled exactly one cycle after the accepting edge, in the CAP state, independent of mem_ready.
- A start asserted in the DONE cycle is ignored. A start is accepted only in IDLE, i.e. the cycle after DONE at the earliest.
- pc_out and flags_out hold their last value until overwritten by a later pop sequence or cleared by reset.

## Test plan
- Reset, then CALL with pc_in=0x0001_2345 and mem_ready=1:
  - Two push cycles, src 01 then 10.
  - DONE at cycle 3; no pc_load; stall high for cycles 0–3.
- INT with flags_in=3'b101 and pc_in=0xABCD_0010:
  - Pushes with src 00, 01, 10 in that order.
  - memory_write high on all three; pc_in changed mid-sequence has no effect.
- RTI with mem_rdata returning 0x0010, 0xABCD, 0x0005 on the capture cycles:
  - DONE with pc_out=0xABCD_0010 and flags_out=3'b101.
  - pc_load and flags_load each high for exactly one cycle.
- RET with mem_ready low for 2 cycles during POP_HI:
  - memory_pop held stable through the wait.
  - DONE at cycle 7; pc_out correct.
- start_int and start_ret asserted together in IDLE:
  - INT sequence only.
  - start_call asserted mid-sequence is ignored.
- reset=0 asserted during CAP_HI of an RTI:
  - Next cycle: IDLE, all outputs 0, pc_out=0, no strobes.

Source files
------------

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle initiator for the memory stage's SP-relative
// stack port. Runs CALL/INT push sequences and RET/RTI pop sequences, one
// request per accepted memory cycle, reassembling popped words into PC/flags.
module stack_sequencer #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_call,
  input  logic              start_ret,
  input  logic              start_int,
  input  logic              start_rti,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              memory_push,
  output logic              memory_pop,
  output logic              memory_write,
  output logic              memory_read,
  output logic [1:0]        memory_address_select,
  output logic [1:0]        memory_write_src_select,
  output logic              stall,
  output logic              busy,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] PUSH_FL = 4'd1;
  localparam logic [3:0] PUSH_HI = 4'd2;
  localparam logic [3:0] PUSH_LO = 4'd3;
  localparam logic [3:0] POP_LO  = 4'd4;
  localparam logic [3:0] CAP_LO  = 4'd5;
  localparam logic [3:0] POP_HI  = 4'd6;
  localparam logic [3:0] CAP_HI  = 4'd7;
  localparam logic [3:0] POP_FL  = 4'd8;
  localparam logic [3:0] CAP_FL  = 4'd9;
  localparam logic [3:0] DONE    = 4'd10;

  localparam logic [1:0] OP_CALL = 2'd0;
  localparam logic [1:0] OP_RET  = 2'd1;
  localparam logic [1:0] OP_INT  = 2'd2;
  localparam logic [1:0] OP_RTI  = 2'd3;

  localparam logic [1:0] SRC_FL = 2'b00;
  localparam logic [1:0] SRC_HI = 2'b01;
  localparam logic [1:0] SRC_LO = 2'b10;

  logic [3:0]        state, next_state;
  logic [1:0]        op, next_op;
  logic [PC_W-1:0]   pc_lat;
  logic [FLAG_W-1:0] flags_lat;
  logic              unused_latched;

  // Operands are captured at start for observability; the memory stage
  // itself picks the write data through memory_write_src_select.
  assign unused_latched = ^{pc_lat, flags_lat};

  assign memory_address_select = 2'b00;
  assign stall = busy | start_call | start_ret | start_int | start_rti;

  // Next-state and operation selection; starts are only arbitrated in IDLE.
  always_comb begin
    next_state = state;
    next_op    = op;
    case (state)
      IDLE: begin
        if (start_int) begin
          next_state = PUSH_FL;
          next_op    = OP_INT;
        end else if (start_rti) begin
          next_state = POP_LO;
          next_op    = OP_RTI;
        end else if (start_call) begin
          next_state = PUSH_HI;
          next_op    = OP_CALL;
        end else if (start_ret) begin
          next_state = POP_LO;
          next_op    = OP_RET;
        end
      end
      PUSH_FL: if (mem_ready) next_state = PUSH_HI;
      PUSH_HI: if (mem_ready) next_state = PUSH_LO;
      PUSH_LO: if (mem_ready) next_state = DONE;
      POP_LO:  if (mem_ready) next_state = CAP_LO;
      CAP_LO:  next_state = POP_HI;
      POP_HI:  if (mem_ready) next_state = CAP_HI;
      CAP_HI:  next_state = (op == OP_RTI) ? POP_FL : DONE;
      POP_FL:  if (mem_ready) next_state = CAP_FL;
      CAP_FL:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, operation and operand latches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= OP_CALL;
      pc_lat    <= '0;
      flags_lat <= '0;
    end else begin
      state <= next_state;
      op    <= next_op;
      if (state == IDLE && next_state != IDLE) begin
        pc_lat    <= pc_in;
        flags_lat <= flags_in;
      end
    end
  end

  // Moore outputs registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      memory_push             <= 1'b0;
      memory_write            <= 1'b0;
      memory_pop              <= 1'b0;
      memory_read             <= 1'b0;
      memory_write_src_select <= SRC_FL;
      busy                    <= 1'b0;
      pc_load                 <= 1'b0;
      flags_load              <= 1'b0;
    end else begin
      memory_push  <= (next_state == PUSH_FL) || (next_state == PUSH_HI) || (next_state == PUSH_LO);
      memory_write <= (next_state == PUSH_FL) || (next_state == PUSH_HI) || (next_state == PUSH_LO);
      memory_pop   <= (next_state == POP_LO) || (next_state == POP_HI) || (next_state == POP_FL);
      memory_read  <= (next_state == POP_LO) || (next_state == POP_HI) || (next_state == POP_FL);
      busy         <= (next_state != IDLE);
      pc_load      <= (next_state == DONE) && ((next_op == OP_RET) || (next_op == OP_RTI));
      flags_load   <= (next_state == DONE) && (next_op == OP_RTI);
      case (next_state)
        PUSH_HI: memory_write_src_select <= SRC_HI;
        PUSH_LO: memory_write_src_select <= SRC_LO;
        default: memory_write_src_select <= SRC_FL;
      endcase
    end
  end

  // Pop data capture: mem_rdata is valid in the CAP cycle after an accepted pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out    <= '0;
      flags_out <= '0;
    end else begin
      if (state == CAP_LO) pc_out[DATA_W-1:0]      <= mem_rdata;
      if (state == CAP_HI) pc_out[PC_W-1:DATA_W]   <= mem_rdata;
      if (state == CAP_FL) flags_out               <= mem_rdata[FLAG_W-1:0];
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: directed per-cycle stimulus tables, a
// step-list behavioural model compared every cycle, plus literal checks.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_call, start_ret, start_int, start_rti;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        memory_push, memory_pop, memory_write, memory_read;
  logic [1:0]  memory_address_select, memory_write_src_select;
  logic        stall, busy, pc_load, flags_load;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  stack_sequencer #(.DATA_W(16), .PC_W(32), .FLAG_W(3)) dut (
    .clk(clk), .reset(reset),
    .start_call(start_call), .start_ret(start_ret),
    .start_int(start_int), .start_rti(start_rti),
    .pc_in(pc_in), .flags_in(flags_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .memory_write(memory_write), .memory_read(memory_read),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .stall(stall), .busy(busy),
    .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is a list of steps: kind 0 push, 1 pop, 2 capture, 3 done;
  // the low two bits name the word (0 flags, 1 PC high, 2 PC low).
  int unsigned steps[$];
  bit          m_active = 1'b0;
  int          m_op = 0;           // 0 CALL, 1 RET, 2 INT, 3 RTI
  logic [31:0] m_pc = '0;
  logic [2:0]  m_fl = '0;
  bit          cmp_en = 1'b0;

  function automatic int unsigned stp(input int unsigned kind, input int unsigned word);
    return (kind << 2) | word;
  endfunction

  always @(posedge clk) begin
    int unsigned cur;
    if (!reset) begin
      m_active = 1'b0;
      steps.delete();
      m_pc = '0;
      m_fl = '0;
    end else if (!m_active) begin
      if (start_int || start_rti || start_call || start_ret) begin
        steps.delete();
        if (start_int) begin
          m_op = 2;
          steps = '{stp(0,0), stp(0,1), stp(0,2), stp(3,0)};
        end else if (start_rti) begin
          m_op = 3;
          steps = '{stp(1,0), stp(2,2), stp(1,0), stp(2,1), stp(1,0), stp(2,0), stp(3,0)};
        end else if (start_call) begin
          m_op = 0;
          steps = '{stp(0,1), stp(0,2), stp(3,0)};
        end else begin
          m_op = 1;
          steps = '{stp(1,0), stp(2,2), stp(1,0), stp(2,1), stp(3,0)};
        end
        m_active = 1'b1;
      end
    end else begin
      cur = steps[0];
      if (!((cur >> 2) <= 1 && !mem_ready)) begin
        if ((cur >> 2) == 2) begin
          case (cur & 3)
            0: m_fl = mem_rdata[2:0];
            1: m_pc[31:16] = mem_rdata;
            default: m_pc[15:0] = mem_rdata;
          endcase
        end
        void'(steps.pop_front());
        if (steps.size() == 0) m_active = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int unsigned kind, word;
    if (cmp_en) begin
      kind = m_active ? (steps[0] >> 2) : 4;
      word = m_active ? (steps[0] & 3) : 0;
      check("push",       memory_push,  kind == 0);
      check("write",      memory_write, kind == 0);
      check("pop",        memory_pop,   kind == 1);
      check("read",       memory_read,  kind == 1);
      check("addr_sel",   memory_address_select, 0);
      check("src_sel",    memory_write_src_select, (kind == 0) ? word : 0);
      check("busy",       busy, m_active);
      check("stall",      stall, m_active | start_int | start_rti | start_call | start_ret);
      check("pc_load",    pc_load,    kind == 3 && (m_op == 1 || m_op == 3));
      check("flags_load", flags_load, kind == 3 && m_op == 3);
      check("pc_out",     pc_out, m_pc);
      check("flags_out",  flags_out, m_fl);
    end
  end

  // ---------------- directed stimulus ----------------
  // Per-cycle tables; cycle 0 is the cycle in which the first start is driven.
  logic [3:0]  cyc_st[32];    // {int, rti, call, ret}
  logic        cyc_rdy[32];
  logic [15:0] cyc_rd[32];
  logic        cyc_rstn[32];

  int          busy_cnt, stall_cnt, push_cnt, pop_cnt, write_cnt, pcl_cnt, fll_cnt, pcl_cyc;
  logic [11:0] push_log;

  task automatic clear_tab();
    for (int i = 0; i < 32; i++) begin
      cyc_st[i]   = 4'b0000;
      cyc_rdy[i]  = 1'b1;
      cyc_rd[i]   = 16'hDEAD;
      cyc_rstn[i] = 1'b1;
    end
  endtask

  task automatic run_seq(input logic [31:0] pc, input logic [2:0] fl, input int ncyc);
    busy_cnt = 0; stall_cnt = 0; push_cnt = 0; pop_cnt = 0; write_cnt = 0;
    pcl_cnt = 0; fll_cnt = 0; pcl_cyc = -1; push_log = '0;
    for (int k = 0; k < ncyc; k++) begin
      {start_int, start_rti, start_call, start_ret} = cyc_st[k];
      pc_in     = (k == 0) ? pc : ~pc;
      flags_in  = (k == 0) ? fl : ~fl;
      mem_ready = cyc_rdy[k];
      mem_rdata = cyc_rd[k];
      reset     = cyc_rstn[k];
      @(negedge clk);
      busy_cnt  += busy;
      stall_cnt += stall;
      push_cnt  += memory_push;
      pop_cnt   += memory_pop;
      write_cnt += memory_write;
      pcl_cnt   += pc_load;
      fll_cnt   += flags_load;
      if (pc_load) pcl_cyc = k;
      if (memory_push) push_log = {push_log[9:0], memory_write_src_select};
      @(posedge clk);
      #1;
    end
    {start_int, start_rti, start_call, start_ret} = 4'b0000;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    {start_int, start_rti, start_call, start_ret} = 4'b0000;
    pc_in = '0; flags_in = '0; mem_ready = 1'b1; mem_rdata = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("reset_busy",   busy, 0);
    check("reset_pc_out", pc_out, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // CALL: pushes PC high then low, DONE at cycle 3, no load strobe
    clear_tab();
    cyc_st[0] = 4'b0010;
    run_seq(32'h0001_2345, 3'b000, 6);
    check("call_busy_cycles",  busy_cnt, 3);
    check("call_stall_cycles", stall_cnt, 4);
    check("call_push_cnt",     push_cnt, 2);
    check("call_src_order",    push_log, 12'b0000_0000_0110);
    check("call_no_pc_load",   pcl_cnt, 0);

    // INT: pushes flags, PC high, PC low; pc_in changes after start
    clear_tab();
    cyc_st[0] = 4'b1000;
    run_seq(32'hABCD_0010, 3'b101, 7);
    check("int_busy_cycles", busy_cnt, 4);
    check("int_write_cnt",   write_cnt, 3);
    check("int_src_order",   push_log, 12'b0000_0000_0110);
    check("int_no_loads",    pcl_cnt + fll_cnt, 0);

    // RTI: mem_ready low in capture cycles must not matter
    clear_tab();
    cyc_st[0] = 4'b0100;
    cyc_rd[2] = 16'h0010; cyc_rd[4] = 16'hABCD; cyc_rd[6] = 16'h0005;
    cyc_rdy[2] = 1'b0; cyc_rdy[4] = 1'b0; cyc_rdy[6] = 1'b0;
    run_seq(32'h0, 3'b000, 10);
    check("rti_busy_cycles", busy_cnt, 7);
    check("rti_done_cycle",  pcl_cyc, 7);
    check("rti_pc_load_cnt", pcl_cnt, 1);
    check("rti_fl_load_cnt", fll_cnt, 1);
    check("rti_pc_out",      pc_out, 32'hABCD_0010);
    check("rti_flags_out",   flags_out, 3'b101);

    // RET with two wait cycles in POP_HI
    clear_tab();
    cyc_st[0] = 4'b0001;
    cyc_rd[2] = 16'h5678; cyc_rd[6] = 16'h1234;
    cyc_rdy[3] = 1'b0; cyc_rdy[4] = 1'b0;
    run_seq(32'h0, 3'b000, 10);
    check("ret_busy_cycles", busy_cnt, 7);
    check("ret_done_cycle",  pcl_cyc, 7);
    check("ret_pop_cycles",  pop_cnt, 4);
    check("ret_no_fl_load",  fll_cnt, 0);
    check("ret_pc_out",      pc_out, 32'h1234_5678);
    check("ret_flags_hold",  flags_out, 3'b101);

    // INT wins over RET; CALL mid-sequence ignored
    clear_tab();
    cyc_st[0] = 4'b1001;
    cyc_st[2] = 4'b0010;
    run_seq(32'h0, 3'b010, 7);
    check("arb_busy_cycles", busy_cnt, 4);
    check("arb_push_cnt",    push_cnt, 3);
    check("arb_pop_cnt",     pop_cnt, 0);

    // Start in DONE dropped; start the cycle after DONE accepted
    clear_tab();
    cyc_st[0] = 4'b0010;
    cyc_st[3] = 4'b0001;
    cyc_st[4] = 4'b0010;
    run_seq(32'h0, 3'b000, 10);
    check("done_busy_cycles", busy_cnt, 6);
    check("done_pop_cnt",     pop_cnt, 0);
    check("done_push_cnt",    push_cnt, 4);

    // Reset during CAP_HI of an RTI aborts without strobes
    clear_tab();
    cyc_st[0] = 4'b0100;
    cyc_rd[2] = 16'h0010;
    cyc_rstn[4] = 1'b0;
    run_seq(32'h0, 3'b000, 8);
    check("rst_busy_cycles", busy_cnt, 4);
    check("rst_no_loads",    pcl_cnt + fll_cnt, 0);
    check("rst_pc_out",      pc_out, 32'h0);
    check("rst_flags_out",   flags_out, 3'b000);
    check("rst_busy",        busy, 0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
